// File: rtl/pc_trace_monitor.sv
// Program-counter trace monitor: classifies each pc step as sequential, stall or jump,
// counts stalls/jumps and queues {from,to} pairs of every jump in a small trace FIFO.
module pc_trace_monitor #(
  parameter int PC_WIDTH  = 8,
  parameter int DEPTH     = 8,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [PC_WIDTH-1:0]  pc,
  input  logic                 clear,
  output logic                 trace_valid,
  input  logic                 trace_ready,
  output logic [PC_WIDTH-1:0]  trace_from,
  output logic [PC_WIDTH-1:0]  trace_to,
  output logic [CNT_WIDTH-1:0] jump_cnt,
  output logic [CNT_WIDTH-1:0] stall_cnt,
  output logic                 overflow
);

  localparam int AW = $clog2(DEPTH);

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  logic [PC_WIDTH-1:0]   prev_pc_p1;
  logic                  vld_p1;
  logic [PC_WIDTH-1:0]   seq_pc;
  logic                  is_stall;
  logic                  is_jump;
  logic [2*PC_WIDTH-1:0] mem [DEPTH];
  logic [AW:0]           wr_ptr;
  logic [AW:0]           rd_ptr;
  logic                  empty;
  logic                  full;
  logic                  pop;
  logic                  push_ok;
  logic                  drop;

  // Stage p1: previous pc, unclassified until one cycle has been sampled
  always_ff @(posedge clk) begin
    if (!rst) begin
      prev_pc_p1 <= '0;
      vld_p1     <= 1'b0;
    end else begin
      prev_pc_p1 <= pc;
      vld_p1     <= 1'b1;
    end
  end

  // Classification against p1: seq compare wraps at PC_WIDTH bits
  assign seq_pc   = prev_pc_p1 + PC_WIDTH'(1);
  assign is_stall = vld_p1 && (pc == prev_pc_p1);
  assign is_jump  = vld_p1 && (pc != prev_pc_p1) && (pc != seq_pc);

  // Extra pointer bit tells full from empty so every slot is usable
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop     = !empty && trace_ready && !clear;
  assign push_ok = rst && !clear && is_jump && (!full || pop);
  assign drop    = rst && !clear && is_jump && full && !pop;

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      jump_cnt  <= '0;
      stall_cnt <= '0;
      overflow  <= 1'b0;
    end else if (clear) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      jump_cnt  <= '0;
      stall_cnt <= '0;
      overflow  <= 1'b0;
    end else begin
      if (is_stall) stall_cnt <= sat_inc(stall_cnt);
      if (is_jump)  jump_cnt  <= sat_inc(jump_cnt);
      if (pop)      rd_ptr    <= rd_ptr + (AW+1)'(1);
      if (push_ok)  wr_ptr    <= wr_ptr + (AW+1)'(1);
      if (drop)     overflow  <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= {prev_pc_p1, pc};
  end

  assign trace_valid = !empty;
  assign trace_from  = mem[rd_ptr[AW-1:0]][2*PC_WIDTH-1:PC_WIDTH];
  assign trace_to    = mem[rd_ptr[AW-1:0]][PC_WIDTH-1:0];

endmodule

// File: tb/tb_pc_trace_monitor.sv
// Bench for pc_trace_monitor: directed scenarios and random traffic compared every cycle
// against a queue-based reference model.
module tb_pc_trace_monitor;

  localparam int PCW   = 8;
  localparam int DEP   = 8;
  localparam int CNTW  = 5;
  localparam int MAXC  = (1 << CNTW) - 1;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [PCW-1:0]  pc = '0;
  logic            clear = 1'b0;
  logic            trace_ready = 1'b0;
  logic            trace_valid;
  logic [PCW-1:0]  trace_from;
  logic [PCW-1:0]  trace_to;
  logic [CNTW-1:0] jump_cnt;
  logic [CNTW-1:0] stall_cnt;
  logic            overflow;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  logic [2*PCW-1:0] mq[$];
  int               m_jumps;
  int               m_stalls;
  bit               m_ovf;
  bit               m_pvalid;
  logic [PCW-1:0]   m_prev;

  pc_trace_monitor #(.PC_WIDTH(PCW), .DEPTH(DEP), .CNT_WIDTH(CNTW)) dut (
    .clk(clk), .rst(rst), .pc(pc), .clear(clear),
    .trace_valid(trace_valid), .trace_ready(trace_ready),
    .trace_from(trace_from), .trace_to(trace_to),
    .jump_cnt(jump_cnt), .stall_cnt(stall_cnt), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic int sat(input int v);
    return (v > MAXC) ? MAXC : v;
  endfunction

  task automatic model_step(input logic r, input logic [PCW-1:0] p, input logic c,
                            input logic rd);
    bit pop;
    bit stl;
    bit jmp;
    if (!r) begin
      mq.delete();
      m_jumps = 0; m_stalls = 0; m_ovf = 0; m_pvalid = 0; m_prev = '0;
      return;
    end
    pop = (mq.size() > 0) && rd;
    stl = 0;
    jmp = 0;
    if (m_pvalid) begin
      if (p == m_prev) stl = 1;
      else if (p != PCW'(m_prev + 1)) jmp = 1;
    end
    if (c) begin
      mq.delete();
      m_jumps = 0; m_stalls = 0; m_ovf = 0;
    end else begin
      if (stl) m_stalls++;
      if (jmp) m_jumps++;
      if (pop) void'(mq.pop_front());
      if (jmp) begin
        if (mq.size() < DEP) mq.push_back({m_prev, p});
        else m_ovf = 1;
      end
    end
    m_prev   = p;
    m_pvalid = 1;
  endtask

  task automatic compare_all();
    check("valid", 32'(trace_valid), 32'(mq.size() != 0));
    if (mq.size() != 0) begin
      check("from", 32'(trace_from), 32'(mq[0][2*PCW-1:PCW]));
      check("to",   32'(trace_to),   32'(mq[0][PCW-1:0]));
    end
    check("jump_cnt",  32'(jump_cnt),  32'(sat(m_jumps)));
    check("stall_cnt", 32'(stall_cnt), 32'(sat(m_stalls)));
    check("overflow",  32'(overflow),  32'(m_ovf));
  endtask

  task automatic cycle(input logic r, input logic [PCW-1:0] p, input logic c, input logic rd);
    rst = r; pc = p; clear = c; trace_ready = rd;
    model_step(r, p, c, rd);
    @(posedge clk);
    #1;
    compare_all();
  endtask

  initial begin
    logic [PCW-1:0] rp;
    int sel;

    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    check("rst_valid", 32'(trace_valid), 32'd0);

    // sequential run after release
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, PCW'(i), 1'b0, 1'b0);
      check("seq_jump", 32'(jump_cnt), 32'd0);
      check("seq_valid", 32'(trace_valid), 32'd0);
    end
    check("seq_stall", 32'(stall_cnt), 32'd0);

    // wrap counts as sequential, then a stall and one jump
    cycle(1'b1, 8'hFE, 1'b1, 1'b0);
    cycle(1'b1, 8'hFF, 1'b0, 1'b0);
    cycle(1'b1, 8'h00, 1'b0, 1'b0);
    cycle(1'b1, 8'h00, 1'b0, 1'b0);
    cycle(1'b1, 8'h10, 1'b0, 1'b0);
    check("wrap_stall", 32'(stall_cnt), 32'd1);
    check("wrap_jump", 32'(jump_cnt), 32'd1);
    check("wrap_valid", 32'(trace_valid), 32'd1);
    check("wrap_from", 32'(trace_from), 32'h00);
    check("wrap_to", 32'(trace_to), 32'h10);

    // nine jumps into an eight-deep FIFO, then drain
    cycle(1'b1, 8'h10, 1'b1, 1'b0);
    for (int i = 1; i <= 9; i++) cycle(1'b1, PCW'(8'h10 + i * 8'h20), 1'b0, 1'b0);
    check("ovf_jump", 32'(jump_cnt), 32'd9);
    check("ovf_flag", 32'(overflow), 32'd1);
    check("ovf_size", 32'(mq.size()), 32'd8);
    for (int i = 0; i < 9; i++) cycle(1'b1, 8'h30, 1'b0, 1'b1);
    check("ovf_sticky", 32'(overflow), 32'd1);
    check("drained", 32'(trace_valid), 32'd0);

    // full FIFO with simultaneous pop accepts the new jump
    cycle(1'b1, 8'h40, 1'b1, 1'b0);
    for (int i = 1; i <= 8; i++) cycle(1'b1, PCW'(8'h40 + i * 8'h11), 1'b0, 1'b0);
    cycle(1'b1, 8'h05, 1'b0, 1'b1);
    check("fullpop_ovf", 32'(overflow), 32'd0);
    check("fullpop_size", 32'(mq.size()), 32'd8);
    for (int i = 0; i < 9; i++) cycle(1'b1, 8'h05, 1'b0, 1'b1);

    // clear wins over a coincident jump
    for (int i = 1; i <= 3; i++) cycle(1'b1, PCW'(i * 8'h30), 1'b0, 1'b0);
    cycle(1'b1, 8'h07, 1'b1, 1'b0);
    check("clr_valid", 32'(trace_valid), 32'd0);
    check("clr_jump", 32'(jump_cnt), 32'd0);
    check("clr_ovf", 32'(overflow), 32'd0);

    // one-cycle reset mid-stream; first cycle after release is unclassified
    for (int i = 1; i <= 3; i++) cycle(1'b1, PCW'(i * 8'h25), 1'b0, 1'b0);
    cycle(1'b0, 8'h50, 1'b0, 1'b0);
    check("rst_mid_valid", 32'(trace_valid), 32'd0);
    cycle(1'b1, 8'h90, 1'b0, 1'b0);
    check("rst_first_jump", 32'(jump_cnt), 32'd0);

    // random traffic
    rp = 8'h90;
    for (int i = 0; i < 3000; i++) begin
      sel = $urandom_range(0, 99);
      if (sel < 45)      rp = rp + 8'h01;
      else if (sel < 70) rp = rp;
      else               rp = PCW'($urandom);
      cycle(($urandom_range(0, 199) != 0), rp,
            ($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 40));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_trace_monitor.md
PC_TRACE_MONITOR -- requirements
Module: pc_trace_monitor

Interface
REQ-001 Parameter PC_WIDTH, default 8; width of the monitored program counter, matching the mips_16 `PC_WIDTH` define.
REQ-002 Parameter DEPTH, default 8; trace FIFO entries, a power of two, at least 2.
REQ-003 Parameter CNT_WIDTH, default 16; event counter width.
REQ-004 clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, synchronous and active-low.
REQ-006 pc  input  PC_WIDTH  program counter driven by the core, sampled every cycle.
REQ-007 clear  input  1  synchronous soft clear of the FIFO, counters and overflow flag.
REQ-008 trace_valid  output  1  FIFO head entry is available.
REQ-009 trace_ready  input  1  consumer accepts the head entry.
REQ-010 trace_from  output  PC_WIDTH  pc value before the discontinuity (head entry).
REQ-011 trace_to  output  PC_WIDTH  pc value after the discontinuity (head entry).
REQ-012 jump_cnt  output  CNT_WIDTH  count of discontinuities since reset or clear.
REQ-013 stall_cnt  output  CNT_WIDTH  count of held-pc cycles since reset or clear.
REQ-014 overflow  output  1  sticky flag: a discontinuity was dropped because the FIFO was full.

Function
REQ-015 The block SHALL register pc into prev_pc every cycle and keep a prev_valid bit.
- prev_valid is 0 after reset and 1 after the first sampled cycle.
REQ-016 No classification SHALL occur while prev_valid=0.
REQ-017 When prev_valid=1, each cycle SHALL be classified as exactly one of:
- SEQ: pc == prev_pc+1, modulo 2^PC_WIDTH, so the all-ones to 0 wrap counts as SEQ.
- STALL: pc == prev_pc.
- JUMP: any other value.
REQ-018 On STALL, stall_cnt SHALL increment by 1, saturating at all-ones.
REQ-019 On JUMP, jump_cnt SHALL increment by 1, saturating at all-ones.
- A push of {prev_pc, pc} SHALL be requested in the same cycle.
REQ-020 A push SHALL be accepted if the FIFO is not full, or if it is full and a pop occurs in the same cycle.
- Otherwise the entry SHALL be dropped and overflow set to 1.
- jump_cnt still increments when the entry is dropped.
REQ-021 A pop SHALL occur when trace_valid=1 and trace_ready=1 in the same cycle.
REQ-022 trace_valid SHALL equal (FIFO not empty), driven from registered state.
- An entry pushed in cycle N is visible as valid in cycle N+1: 1-cycle latency.
REQ-023 trace_from and trace_to SHALL stay stable while trace_valid=1 and no pop occurs.
- Both are don't-care while trace_valid=0.
REQ-024 Simultaneous push and pop on a non-empty FIFO SHALL leave occupancy unchanged and preserve order.
REQ-025 A pop from a FIFO holding a single entry, with no push, SHALL deassert trace_valid in the next cycle.
REQ-026 FIFO read and write pointers SHALL wrap modulo DEPTH.
- Full/empty SHALL be distinguished without losing an entry: all DEPTH entries are usable.
REQ-027 clear=1 SHALL take priority over push, pop and counting in the same cycle.
- Next cycle: FIFO empty, jump_cnt=0, stall_cnt=0, overflow=0.
- prev_pc and prev_valid SHALL continue updating normally.
REQ-028 overflow SHALL remain 1 until reset or clear, regardless of later pops.

Reset
REQ-029 While rst=0 at a clock edge, the block SHALL set all of the following:
- FIFO empty, trace_valid=0.
- jump_cnt=0, stall_cnt=0, overflow=0.
- prev_valid=0, prev_pc=0.
REQ-030 Reset asserted mid-operation SHALL discard all FIFO contents and counts within one cycle.
- The first cycle after release SHALL be unclassified, per REQ-016.

Verification
REQ-031 Reset release, then pc=0,1,2,3 -> jump_cnt=0, stall_cnt=0, trace_valid=0 throughout.
REQ-032 PC_WIDTH=8, pc=8'hFE,8'hFF,8'h00,8'h00,8'h10 -> stall_cnt=1, jump_cnt=1.
- Entry {from=8'h00, to=8'h10} is valid the cycle after pc=8'h10.
REQ-033 trace_ready=0, 9 consecutive jumps with DEPTH=8 -> 8 entries held, overflow=1, jump_cnt=9.
- Draining yields the first 8 jumps in order.
REQ-034 FIFO full, jump coincides with trace_ready=1 -> no overflow, occupancy stays 8, new entry last.
REQ-035 clear=1 in the same cycle as a jump with 3 entries queued -> next cycle trace_valid=0, jump_cnt=0, overflow=0.
REQ-036 rst=0 for one cycle mid-stream with entries queued -> trace_valid=0 next cycle.
- pc jump on the first cycle after release is not counted.
